// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, followed by a single sign-correction cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_UMULL = 3'b001;
  localparam logic [2:0] OP_SMULL = 3'b010;
  localparam logic [2:0] OP_UDIV  = 3'b100;
  localparam logic [2:0] OP_SDIV  = 3'b101;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x, input logic sgn);
    logic [WIDTH-1:0] r;
    if (sgn && x[WIDTH-1]) r = neg_w(x);
    else                   r = x;
    return r;
  endfunction

  function automatic logic op_legal(input logic [2:0] o);
    logic r;
    case (o)
      OP_MUL, OP_UMULL, OP_SMULL, OP_UDIV, OP_SDIV: r = 1'b1;
      default:                                      r = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mc_q, mc_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, ovf_q, ovf_d, spec_q, spec_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic [3:0]       flags_q, flags_d;

  logic               accept_s, is_signed_s, special_s, geq_s;
  logic [WIDTH:0]     add_s, sh_s;
  logic [WIDTH-1:0]   sub_s, fin_lo_s, fin_hi_s;
  logic [2*WIDTH-1:0] prod_s, nprod_s;
  logic [3:0]         fin_flags_s;

  assign accept_s    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign is_signed_s = (op == OP_SMULL) || (op == OP_SDIV);
  assign special_s   = !op_legal(op) || (op[2] && (b == {WIDTH{1'b0}}));
  assign add_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : {(WIDTH+1){1'b0}});
  assign sh_s    = {hi_q, lo_q[WIDTH-1]};
  assign geq_s   = (sh_s >= {1'b0, mc_q});
  assign sub_s   = sh_s[WIDTH-1:0] - mc_q;
  assign prod_s  = {hi_q, lo_q};
  assign nprod_s = (~prod_s) + {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Final result selection with sign correction, evaluated during FIX
  always_comb begin
    fin_lo_s = {WIDTH{1'b0}};
    fin_hi_s = {WIDTH{1'b0}};
    if (spec_q) begin
      fin_hi_s = hi_q;
    end else begin
      case (op_q)
        OP_MUL:   fin_lo_s = lo_q;
        OP_UMULL: {fin_hi_s, fin_lo_s} = prod_s;
        OP_SMULL: {fin_hi_s, fin_lo_s} = neg_q ? nprod_s : prod_s;
        OP_UDIV:  begin fin_lo_s = lo_q; fin_hi_s = hi_q; end
        OP_SDIV:  begin
          fin_lo_s = neg_q  ? neg_w(lo_q) : lo_q;
          fin_hi_s = rneg_q ? neg_w(hi_q) : hi_q;
        end
        default:  fin_lo_s = {WIDTH{1'b0}};
      endcase
    end
    fin_flags_s[3] = ((op_q == OP_UMULL) || (op_q == OP_SMULL)) ? fin_hi_s[WIDTH-1]
                                                               : fin_lo_s[WIDTH-1];
    fin_flags_s[2] = (fin_lo_s == {WIDTH{1'b0}}) && (fin_hi_s == {WIDTH{1'b0}});
    fin_flags_s[1] = 1'b0;
    fin_flags_s[0] = ovf_q && !spec_q;
  end

  // Next-state, datapath iteration and output-register load
  always_comb begin
    state_d  = state_q;  cnt_d  = cnt_q;  op_d   = op_q;
    hi_d     = hi_q;     lo_d   = lo_q;   mc_d   = mc_q;
    neg_d    = neg_q;    rneg_d = rneg_q; ovf_d  = ovf_q; spec_d = spec_q;
    done_d   = 1'b0;     dz_d   = dz_q;
    res_lo_d = res_lo_q; res_hi_d = res_hi_q; flags_d = flags_q;
    if (accept_s) begin
      op_d    = op;
      flags_d = 4'b0000;
      dz_d    = 1'b0;
      neg_d   = is_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_d  = (op == OP_SDIV) && a[WIDTH-1];
      ovf_d   = (op == OP_SDIV) && (a == MOST_NEG) && (b == {WIDTH{1'b1}});
      spec_d  = special_s;
      if (special_s) begin
        // Two FIX cycles keep zero-divide/illegal timing at three edges
        state_d = S_FIX;
        cnt_d   = CW'(1);
        hi_d    = op_legal(op) ? a : {WIDTH{1'b0}};
        lo_d    = {WIDTH{1'b0}};
      end else begin
        state_d = S_CALC;
        cnt_d   = CW'(WIDTH - 1);
        hi_d    = {WIDTH{1'b0}};
        if (op[2]) begin
          lo_d = mag_w(a, is_signed_s);
          mc_d = mag_w(b, is_signed_s);
        end else begin
          lo_d = mag_w(b, is_signed_s);
          mc_d = mag_w(a, is_signed_s);
        end
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_CALC: begin
          if (op_q[2]) begin
            if (geq_s) begin
              hi_d = sub_s;
              lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_d = sh_s[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi_d = add_s[WIDTH:1];
            lo_d = {add_s[0], lo_q[WIDTH-1:1]};
          end
          if (cnt_q == {CW{1'b0}}) state_d = S_FIX;
          else                     cnt_d   = cnt_q - CW'(1);
        end
        S_FIX: begin
          if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            res_lo_d = fin_lo_s;
            res_hi_d = fin_hi_s;
            flags_d  = fin_flags_s;
            dz_d     = spec_q && op_legal(op_q);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;        cnt_q    <= {CW{1'b0}};     op_q   <= 3'b000;
      hi_q     <= {WIDTH{1'b0}}; lo_q     <= {WIDTH{1'b0}};  mc_q   <= {WIDTH{1'b0}};
      neg_q    <= 1'b0;          rneg_q   <= 1'b0;           ovf_q  <= 1'b0;
      spec_q   <= 1'b0;          busy_q   <= 1'b0;           done_q <= 1'b0;
      dz_q     <= 1'b0;          res_lo_q <= {WIDTH{1'b0}};  res_hi_q <= {WIDTH{1'b0}};
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;       cnt_q    <= cnt_d;          op_q   <= op_d;
      hi_q     <= hi_d;          lo_q     <= lo_d;           mc_q   <= mc_d;
      neg_q    <= neg_d;         rneg_q   <= rneg_d;         ovf_q  <= ovf_d;
      spec_q   <= spec_d;        busy_q   <= busy_d;         done_q <= done_d;
      dz_q     <= dz_d;          res_lo_q <= res_lo_d;       res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign flags     = flags_q;
  assign div_zero  = dz_q;

endmodule
